logic_shift_pipe: RTL
=====================

# logic_shift_pipe

Parametrised, pipelined successor to the team's single-stage logic unit. Adds XOR/XNOR, logical shift-left and shift-right, and a valid/ready handshake on both sides. Pipeline depth is configurable, and the whole pipeline stalls under back-pressure. It sits in the signed ALU datapath beside the arithmetic and compare units, and feeds the ALU output mux and a completed-operation counter.

## Interface
- DATA_WIDTH, 16: operand/result width; power of two, ≥ 4.
- STAGES, 2: pipeline register stages, 1..4.
- CNT_WIDTH, 16: width of completed-operation counter.
- CLK  input  1  rising-edge clock.
- RST  input  1  reset, asynchronous, active-low.
- In_Valid  input  1  operands and opcode valid this cycle.
- In_Ready  output  1  block can accept an operation this cycle.
- A  input  DATA_WIDTH  operand A.
- B  input  DATA_WIDTH  operand B; for shifts only B[log2(DATA_WIDTH)-1:0] is used.
- Logic_FUN_SEL  input  3  opcode: 000 AND, 001 OR, 010 NAND, 011 NOR, 100 XOR, 101 XNOR, 110 SHL (A << amt), 111 SHR (A >> amt, logical, zero-fill).
- Out_Valid  output  1  result valid.
- Out_Ready  input  1  downstream accepts the result.
- Logic_OUT  output  DATA_WIDTH  result.
- Logic_Flag  output  1  equals Out_Valid; kept for ALU-mux compatibility.
- Zero_Flag  output  1  result == 0; qualified by Out_Valid.
- Op_Count  output  CNT_WIDTH  count of completed output handshakes; wraps modulo 2^CNT_WIDTH.

## Operation
- Input handshake: accepted when In_Valid && In_Ready. Output handshake: completes when Out_Valid && Out_Ready.
- Result is computed combinationally from A, B and Logic_FUN_SEL at acceptance. It is captured with its zero flag into stage 0.
- Shift amount is B mod DATA_WIDTH. An amount of 0 passes A through unchanged.
- Each stage i holds a valid bit v[i], data d[i] and zero flag z[i]. Stage STAGES-1 drives Out_Valid, Logic_OUT and Zero_Flag.
- Stage readiness:
  - rdy[STAGES-1] = ~v[STAGES-1] | Out_Ready.
  - rdy[i] = ~v[i] | rdy[i+1].
  - In_Ready = rdy[0].
- Stage i loads from stage i-1 (or from the input for i=0) when rdy[i] is high. v[i] takes the upstream valid.
- d[i]/z[i] load only when the upstream valid is high. Otherwise they hold, so Logic_OUT retains the last result after the pipeline drains.
- Back-pressure: while Out_Valid && !Out_Ready, Logic_OUT, Zero_Flag and Out_Valid are held stable. Bubbles upstream are still squeezed out. In_Ready drops only when every stage is full.
- Op_Count increments by 1 on each output handshake and wraps from all-ones to 0.
- No operation is ever dropped or duplicated. Ordering is strictly FIFO.

## Timing
- Reset (async assert, sync release on CLK): all v[i]=0, d[i]=0, z[i]=0, Op_Count=0. Hence Out_Valid=0, Logic_Flag=0, Logic_OUT=0, Zero_Flag=0.
- In_Ready is 1 while in reset and in the first cycle after release.
- Latency: an operation accepted at edge n appears on Out_Valid after edge n+STAGES-1. It is therefore visible in the cycle following edge n+STAGES-1, with no stall.
- Throughput: one operation per cycle with Out_Ready held high.
- Simultaneous input accept and output handshake with a full pipeline is legal. The pipeline advances and In_Ready stays 1.
- Reset asserted mid-operation clears all in-flight operations immediately. They are lost, not delivered.
- In_Ready depends combinationally on Out_Ready: a single-cycle path through all stages. There is no combinational path from In_Valid to Out_Valid.

## Test plan
- Each opcode with DATA_WIDTH=16, STAGES=2, A=16'hF0F0, B=16'h0FF4 and Out_Ready=1 gives, two cycles later:
  - AND 0x00F0; OR 0xFFF4; NAND 0xFF0F; NOR 0x000B;
  - XOR 0xFF04; XNOR 0x00FB;
  - SHL 0x0F00; SHR 0x0F0F.
  - Zero_Flag=0 throughout.
- Shift wrap: SHL A=16'h0001, B=16'h0010 → 0x0001 (amount 0). SHR A=16'h8000, B=16'h001F → 0x0001.
- Zero flag: XOR A=B=16'h1234 → Logic_OUT=0, Zero_Flag=1, Out_Valid=1.
- Back-pressure, STAGES=3:
  - Stream 5 ops with Out_Ready=0. In_Ready falls after the 3rd accept. Logic_OUT holds op #1.
  - Raise Out_Ready. All 5 results emerge in order on consecutive cycles. Op_Count=5.
- Reset mid-stream: assert RST with 2 ops in flight → Out_Valid=0, Logic_OUT=0 and Op_Count=0 immediately. No result appears after release.
- Counter wrap, CNT_WIDTH=4: 17 completed handshakes → Op_Count=1.

Source files
------------

// File: rtl/logic_shift_pipe_if.sv
// Handshake/operand bundle for logic_shift_pipe: request side (In_*, A, B, opcode)
// and result side (Out_*, Logic_OUT, flags).
interface logic_shift_pipe_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  In_Valid;
  logic                  In_Ready;
  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] B;
  logic [2:0]            Logic_FUN_SEL;
  logic                  Out_Valid;
  logic                  Out_Ready;
  logic [DATA_WIDTH-1:0] Logic_OUT;
  logic                  Logic_Flag;
  logic                  Zero_Flag;

  modport master (
    output In_Valid, A, B, Logic_FUN_SEL, Out_Ready,
    input  In_Ready, Out_Valid, Logic_OUT, Logic_Flag, Zero_Flag
  );

  modport slave (
    input  In_Valid, A, B, Logic_FUN_SEL, Out_Ready,
    output In_Ready, Out_Valid, Logic_OUT, Logic_Flag, Zero_Flag
  );
endinterface

// File: rtl/logic_shift_pipe.sv
// Pipelined logic/shift unit with valid/ready on both sides; the whole pipe stalls
// under back-pressure while bubbles are squeezed out, plus a completed-op counter.
module logic_shift_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int STAGES     = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  logic_shift_pipe_if.slave    bus,
  output logic [CNT_WIDTH-1:0] Op_Count
);
  localparam int SH_W = $clog2(DATA_WIDTH);

  logic [SH_W-1:0]       amt;
  logic [DATA_WIDTH-1:0] result;

  logic [STAGES-1:0]                 vld_pipe;
  logic [STAGES-1:0]                 rdy;
  logic [STAGES-1:0][DATA_WIDTH-1:0] d;
  logic [STAGES-1:0]                 z;
  logic [STAGES-1:0]                 up_v;
  logic [STAGES-1:0][DATA_WIDTH-1:0] up_d;
  logic [STAGES-1:0]                 up_z;

  // Shift amount is B mod DATA_WIDTH (DATA_WIDTH is a power of two).
  assign amt = bus.B[SH_W-1:0];

  always_comb begin
    result = '0;
    case (bus.Logic_FUN_SEL)
      3'b000: result = bus.A & bus.B;
      3'b001: result = bus.A | bus.B;
      3'b010: result = ~(bus.A & bus.B);
      3'b011: result = ~(bus.A | bus.B);
      3'b100: result = bus.A ^ bus.B;
      3'b101: result = ~(bus.A ^ bus.B);
      3'b110: result = bus.A << amt;
      3'b111: result = bus.A >> amt;
      default: result = '0;
    endcase
  end

  // Ready ripples back from the output: a stage can load if it is empty or the
  // stage ahead of it is moving.
  for (genvar i = 0; i < STAGES; i++) begin : g_stg
    if (i == 0) begin : g_head
      assign up_v[i] = bus.In_Valid;
      assign up_d[i] = result;
      assign up_z[i] = (result == '0);
    end else begin : g_body
      assign up_v[i] = vld_pipe[i-1];
      assign up_d[i] = d[i-1];
      assign up_z[i] = z[i-1];
    end
    if (i == STAGES-1) begin : g_tail_rdy
      assign rdy[i] = ~vld_pipe[i] | bus.Out_Ready;
    end else begin : g_rdy
      assign rdy[i] = ~vld_pipe[i] | rdy[i+1];
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      vld_pipe <= '0;
      d        <= '0;
      z        <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (rdy[i]) begin
          vld_pipe[i] <= up_v[i];
          // Data holds across bubbles so Logic_OUT keeps the last result when drained.
          if (up_v[i]) begin
            d[i] <= up_d[i];
            z[i] <= up_z[i];
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                              Op_Count <= '0;
    else if (bus.Out_Valid && bus.Out_Ready) Op_Count <= Op_Count + CNT_WIDTH'(1);
  end

  assign bus.In_Ready   = rdy[0];
  assign bus.Out_Valid  = vld_pipe[STAGES-1];
  assign bus.Logic_Flag = vld_pipe[STAGES-1];
  assign bus.Logic_OUT  = d[STAGES-1];
  assign bus.Zero_Flag  = z[STAGES-1];
endmodule
